// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority per bit, false-start rejection,
// parity/framing/break/overrun reporting, single-entry valid/ready output register.
module uart_rx_param #(
   parameter int CLOCK_FREQ  = 50_000_000,
   parameter int UART_BAUD   = 115200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 uart_rx_path,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_break,
   output logic                 rx_overrun,
   output logic                 busy
);
   localparam logic [31:0] BIT_N     = 32'(CLOCK_FREQ / UART_BAUD);
   localparam logic [31:0] HALF_N    = BIT_N / 32'd2;
   localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_PARITY    = 3'd3;
   localparam logic [2:0] ST_STOP      = 3'd4;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES:0]   vld_q, vld_d;
   logic                   prev_q, prev_d, armed_q, armed_d;
   logic [2:0]             state_q, state_d;
   logic [31:0]            cnt_q, cnt_d;
   logic [3:0]             idx_q, idx_d;
   logic [1:0]             samp_q, samp_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   zero_q, zero_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d, oerr_p_q, oerr_p_d, oerr_f_q, oerr_f_d;
   logic                   obrk_q, obrk_d, ovr_q, ovr_d;
   logic                   line, bit_v, tick, done, fe_fin, brk_fin, exp_par, load;

   always_comb begin
      line    = sync_q[SYNC_STAGES-1];
      sync_d  = {sync_q[SYNC_STAGES-2:0], uart_rx_path};
      // Edge detection is armed only once a genuine high has reached prev post-reset.
      vld_d   = {vld_q[SYNC_STAGES-1:0], 1'b1};
      prev_d  = line;
      armed_d = armed_q | (vld_q[SYNC_STAGES] & prev_q);

      tick    = (cnt_q == HALF_N + 32'd1);
      bit_v   = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);
      exp_par = (PARITY == 1) ? ~(^shift_q) : ^shift_q;
      samp_d  = samp_q;
      if (cnt_q == HALF_N - 32'd1) samp_d[0] = line;
      if (cnt_q == HALF_N)         samp_d[1] = line;

      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      zero_d  = zero_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      brk_d   = brk_q;
      done    = 1'b0;
      fe_fin  = ferr_q;
      brk_fin = brk_q;

      case (state_q)
         ST_IDLE: if (armed_q && prev_q && !line) state_d = ST_START;
         ST_START: if (tick) begin
            if (bit_v) state_d = ST_IDLE;
            else begin
               state_d = ST_DATA;
               idx_d   = 4'd0;
               zero_d  = 1'b1;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
               brk_d   = 1'b0;
            end
         end
         ST_DATA: if (tick) begin
            shift_d = {bit_v, shift_q[DATA_BITS-1:1]};
            zero_d  = zero_q & ~bit_v;
            if (idx_q == LAST_DATA) begin
               idx_d   = 4'd0;
               state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else idx_d = idx_q + 4'd1;
         end
         ST_PARITY: if (tick) begin
            perr_d  = bit_v ^ exp_par;
            zero_d  = zero_q & ~bit_v;
            state_d = ST_STOP;
         end
         ST_STOP: if (tick) begin
            fe_fin  = ferr_q | ~bit_v;
            brk_fin = (idx_q == 4'd0) ? (zero_q & ~bit_v) : brk_q;
            ferr_d  = fe_fin;
            brk_d   = brk_fin;
            if (idx_q == LAST_STOP) begin
               done    = 1'b1;
               state_d = fe_fin ? ST_WAIT_HIGH : ST_IDLE;
            end else idx_d = idx_q + 4'd1;
         end
         ST_WAIT_HIGH: if (line) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (state_q == ST_IDLE || state_d == ST_IDLE) cnt_d = 32'd0;
      else if (cnt_q == BIT_N - 32'd1)              cnt_d = 32'd0;
      else                                          cnt_d = cnt_q + 32'd1;

      // A completed frame loads only if the register is empty or being drained now.
      load     = done & (~valid_q | rx_ready);
      data_d   = load ? shift_q : data_q;
      oerr_p_d = load ? perr_q  : oerr_p_q;
      oerr_f_d = load ? fe_fin  : oerr_f_q;
      obrk_d   = load ? brk_fin : obrk_q;
      if (load)                     valid_d = 1'b1;
      else if (valid_q && rx_ready) valid_d = 1'b0;
      else                          valid_d = valid_q;
      ovr_d    = done & ~load;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync_q   <= '1;
         vld_q    <= '0;
         prev_q   <= 1'b1;
         armed_q  <= 1'b0;
         state_q  <= ST_IDLE;
         cnt_q    <= 32'd0;
         idx_q    <= 4'd0;
         samp_q   <= 2'b00;
         shift_q  <= '0;
         zero_q   <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         brk_q    <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         oerr_p_q <= 1'b0;
         oerr_f_q <= 1'b0;
         obrk_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         vld_q    <= vld_d;
         prev_q   <= prev_d;
         armed_q  <= armed_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         samp_q   <= samp_d;
         shift_q  <= shift_d;
         zero_q   <= zero_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         brk_q    <= brk_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         oerr_p_q <= oerr_p_d;
         oerr_f_q <= oerr_f_d;
         obrk_q   <= obrk_d;
         ovr_q    <= ovr_d;
      end
   end

   assign rx_data       = data_q;
   assign rx_valid      = valid_q;
   assign rx_parity_err = oerr_p_q;
   assign rx_frame_err  = oerr_f_q;
   assign rx_break      = obrk_q;
   assign rx_overrun    = ovr_q;
   assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance at default rates and a fast 7E2 instance,
// driven by serial frames whose expected results come from the framing rules.
module tb_uart_rx_param;
   localparam int NA    = 50_000_000 / 115200;
   localparam int HA    = NA / 2;
   localparam int NB    = 1_600_000 / 100_000;
   localparam int S     = 2;
   localparam int LAT_A = 9 * NA + (HA + 1) + S + 2;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       line_a, line_b, ready_a, ready_b;
   logic [7:0] rx_data_a;
   logic [6:0] rx_data_b;
   logic       rx_valid_a, rx_parity_err_a, rx_frame_err_a, rx_break_a, rx_overrun_a, busy_a;
   logic       rx_valid_b, rx_parity_err_b, rx_frame_err_b, rx_break_b, rx_overrun_b, busy_b;

   uart_rx_param dut_a (
      .clk_in(clk_in), .rst_in(rst_in), .uart_rx_path(line_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(ready_a),
      .rx_parity_err(rx_parity_err_a), .rx_frame_err(rx_frame_err_a),
      .rx_break(rx_break_a), .rx_overrun(rx_overrun_a), .busy(busy_a)
   );

   uart_rx_param #(
      .CLOCK_FREQ(1_600_000), .UART_BAUD(100_000), .DATA_BITS(7),
      .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(2)
   ) dut_b (
      .clk_in(clk_in), .rst_in(rst_in), .uart_rx_path(line_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(ready_b),
      .rx_parity_err(rx_parity_err_b), .rx_frame_err(rx_frame_err_b),
      .rx_break(rx_break_b), .rx_overrun(rx_overrun_b), .busy(busy_b)
   );

   // clock / reset block
   always #5 clk_in = ~clk_in;
   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // scoreboard: {break, frame_err, parity_err, data}
   logic [11:0] exp_a[$];
   logic [11:0] exp_b[$];
   int n_checks = 0;
   int n_fail   = 0;
   int ovr_a = 0, ovr_b = 0;
   int fall_cyc_a = 0, last_rise_a = 0;
   logic valid_a_prev = 1'b0;
   bit rand_ready = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (!rst_in && rx_valid_a && ready_a) begin
         check("a_frame_expected", 32'(exp_a.size() > 0), 32'd1);
         if (exp_a.size() > 0)
            check("a_frame", 32'({rx_break_a, rx_frame_err_a, rx_parity_err_a, rx_data_a}),
                  32'(exp_a.pop_front()));
      end
      if (!rst_in && rx_valid_b && ready_b) begin
         check("b_frame_expected", 32'(exp_b.size() > 0), 32'd1);
         if (exp_b.size() > 0)
            check("b_frame", 32'({rx_break_b, rx_frame_err_b, rx_parity_err_b, rx_data_b}),
                  32'(exp_b.pop_front()));
      end
      if (!rst_in && rx_overrun_a) ovr_a++;
      if (!rst_in && rx_overrun_b) ovr_b++;
      if (rx_valid_a && !valid_a_prev) last_rise_a = cyc;
      valid_a_prev = rx_valid_a;
   end

   initial begin
      forever begin
         @(posedge clk_in);
         #1;
         if (rand_ready) ready_b = ($urandom_range(0, 3) != 0);
      end
   end

   // driver tasks: all line changes land 1 time unit after a rising edge
   task automatic drive_a(input logic v, input int n);
      line_a = v;
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic drive_b(input logic v, input int n);
      line_b = v;
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic send_a(input logic [7:0] d, input bit push);
      logic [9:0] bits;
      bits = {1'b1, d, 1'b0};
      fall_cyc_a = cyc;
      if (push) exp_a.push_back(12'(d));
      for (int i = 0; i < 10; i++) drive_a(bits[i], NA);
   endtask

   // Even parity: the parity bit makes the total count of ones even.
   task automatic send_b(input logic [6:0] d, input bit flip, input logic [1:0] stops, input bit push);
      logic [10:0] bits;
      logic        pbit, brk, fe, pe;
      pbit = (^d) ^ flip;
      bits = {stops[1], stops[0], pbit, d, 1'b0};
      brk  = (d == 7'd0) && !pbit && !stops[0];
      fe   = (stops != 2'b11);
      pe   = (pbit != (^d));
      if (push) exp_b.push_back({2'b00, brk, fe, pe, d});
      for (int i = 0; i < 11; i++) drive_b(bits[i], NB);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int diff;
      logic [6:0] d;
      logic [1:0] st;
      bit flip;
      rst_in = 1'b1; line_a = 1'b1; line_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
      repeat (4) @(posedge clk_in);
      #1 rst_in = 1'b0;
      check("a_reset_data", 32'(rx_data_a), 32'd0);
      check("a_reset_valid", 32'(rx_valid_a), 32'd0);
      check("a_reset_flags", 32'({rx_parity_err_a, rx_frame_err_a, rx_break_a, rx_overrun_a}), 32'd0);
      check("a_reset_busy", 32'(busy_a), 32'd0);
      check("b_reset_outputs", 32'({rx_data_b, rx_valid_b, rx_parity_err_b, rx_frame_err_b,
                                    rx_break_b, rx_overrun_b, busy_b}), 32'd0);
      drive_a(1'b1, 10);

      // 8N1 0xA5 with latency window
      send_a(8'hA5, 1'b1);
      drive_a(1'b1, 2 * NA);
      diff = last_rise_a - fall_cyc_a;
      check($sformatf("a_valid_latency_%0d_nominal_%0d", diff, LAT_A),
            32'((diff >= LAT_A - 2) && (diff <= LAT_A + 2)), 32'd1);

      // 100-cycle glitch on an idle line is a false start
      drive_a(1'b0, 10);
      check("a_busy_in_glitch", 32'(busy_a), 32'd1);
      drive_a(1'b0, 90);
      drive_a(1'b1, HA + S + 6 - 100);
      check("a_busy_after_glitch", 32'(busy_a), 32'd0);
      check("a_valid_after_glitch", 32'(rx_valid_a), 32'd0);
      drive_a(1'b1, 2 * NA);

      // reset after 4 data bits of 0x0F, then 0xF0
      fork
         send_a(8'h0F, 1'b0);
         begin
            repeat (5 * NA + 10) @(posedge clk_in);
            #1 rst_in = 1'b1;
            @(posedge clk_in);
            #1 rst_in = 1'b0;
            check("a_midreset_data", 32'(rx_data_a), 32'd0);
            check("a_midreset_valid", 32'(rx_valid_a), 32'd0);
            check("a_midreset_flags", 32'({rx_parity_err_a, rx_frame_err_a, rx_break_a, rx_overrun_a}), 32'd0);
            check("a_midreset_busy", 32'(busy_a), 32'd0);
         end
      join
      drive_a(1'b1, 2 * NA);
      send_a(8'hF0, 1'b1);
      drive_a(1'b1, 2 * NA);

      // 7E2: 0x55 with correct then inverted parity
      send_b(7'h55, 1'b0, 2'b11, 1'b1);
      drive_b(1'b1, 2 * NB);
      send_b(7'h55, 1'b1, 2'b11, 1'b1);
      drive_b(1'b1, 2 * NB);

      // overrun: consumer stalled for two frames
      ready_b = 1'b0;
      send_b(7'h11, 1'b0, 2'b11, 1'b1);
      drive_b(1'b1, 2 * NB);
      send_b(7'h22, 1'b0, 2'b11, 1'b0);
      drive_b(1'b1, 2 * NB);
      check("b_ovr_valid_held", 32'(rx_valid_b), 32'd1);
      check("b_ovr_data_held", 32'(rx_data_b), 32'h11);
      check("b_ovr_pulses", 32'(ovr_b), 32'd1);
      ready_b = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      check("b_valid_drop_after_accept", 32'(rx_valid_b), 32'd0);
      @(posedge clk_in);
      #1;

      // line low for 20 bit times: exactly one break frame, then a clean 0x3C
      exp_b.push_back(12'h300);
      drive_b(1'b0, 20 * NB);
      drive_b(1'b1, 4 * NB);
      send_b(7'h3C, 1'b0, 2'b11, 1'b1);
      drive_b(1'b1, 2 * NB);

      // randomized frames with a jittery consumer
      rand_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            d    = 7'd0;
            flip = 1'b0;
            st   = {1'($urandom_range(0, 1)), 1'b0};
         end else begin
            d    = 7'($urandom_range(0, 127));
            flip = ($urandom_range(0, 3) == 0);
            st   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         end
         send_b(d, flip, st, 1'b1);
         drive_b(1'b1, NB * (1 + $urandom_range(0, 2)) + $urandom_range(0, 5));
      end
      rand_ready = 1'b0;
      ready_b = 1'b1;
      drive_b(1'b1, 4 * NB);

      check("a_frames_outstanding", 32'(exp_a.size()), 32'd0);
      check("b_frames_outstanding", 32'(exp_b.size()), 32'd0);
      check("a_overrun_total", 32'(ovr_a), 32'd0);
      check("b_overrun_total", 32'(ovr_b), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
